// File: rtl/branch_early_redirect.sv
// Execute-stage branch redirect controller: detects direction/target
// mispredictions from early-resolved branch operands, waits for the MIPS
// delay slot to reach execute, then raises a held redirect request.

package branch_early_redirect_pkg;

    localparam int unsigned ADDR_W = 32;

    // Early resolution bundle produced alongside operand forwarding.
    typedef struct packed {
        logic              cond_equal;
        logic              cond_sign;
        logic              negate;
        logic              mask_equal;
        logic              mask_sign;
        logic [ADDR_W-1:0] target;
    } branch_early_resolved_t;

endpackage

module branch_early_redirect
    import branch_early_redirect_pkg::*;
#(
    parameter logic [31:0] DS_OFFSET = 32'd8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   br_valid,
    input  logic [ADDR_W-1:0]      br_pc,
    input  branch_early_resolved_t resolved,
    input  logic                   pred_taken,
    input  logic [ADDR_W-1:0]      pred_target,
    input  logic                   ds_valid,
    input  logic                   redirect_ack,
    output logic                   redirect_req,
    output logic [ADDR_W-1:0]      redirect_pc,
    output logic                   hold_issue,
    output logic [ADDR_W-1:0]      mispredict_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_DS = 2'd1,
        S_REQ     = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
    logic [ADDR_W-1:0] mispredict_cnt_q, mispredict_cnt_d;
    logic              redirect_req_q;
    logic              hold_issue_q;

    logic              taken_c;
    logic [ADDR_W-1:0] corrected_pc_c;
    logic              mismatch_c;
    logic              accept_c;

    // Resolve actual direction, corrected next PC and misprediction.
    always_comb begin
        taken_c        = resolved.negate ^ ((resolved.mask_equal & resolved.cond_equal) |
                                            (resolved.mask_sign  & resolved.cond_sign));
        corrected_pc_c = taken_c ? resolved.target : ADDR_W'(br_pc + DS_OFFSET);
        mismatch_c     = (taken_c != pred_taken) |
                         (taken_c & pred_taken & (resolved.target != pred_target));
        accept_c       = br_valid & ~stall & ~flush;
    end

    // Next-state logic: latch on accepted mismatch, wait for delay slot, hold request.
    always_comb begin
        state_d          = state_q;
        redirect_pc_d    = redirect_pc_q;
        mispredict_cnt_d = mispredict_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c && mismatch_c) begin
                    redirect_pc_d    = corrected_pc_c;
                    mispredict_cnt_d = ADDR_W'(mispredict_cnt_q + 32'd1);
                    state_d          = ds_valid ? S_REQ : S_WAIT_DS;
                end
            end
            S_WAIT_DS: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (ds_valid && !stall) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (redirect_ack || flush) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; outputs follow the next state so they
    // line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= S_IDLE;
            redirect_pc_q    <= '0;
            mispredict_cnt_q <= '0;
            redirect_req_q   <= 1'b0;
            hold_issue_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            redirect_pc_q    <= redirect_pc_d;
            mispredict_cnt_q <= mispredict_cnt_d;
            redirect_req_q   <= (state_d == S_REQ);
            hold_issue_q     <= (state_d != S_IDLE);
        end
    end

    assign redirect_req   = redirect_req_q;
    assign redirect_pc    = redirect_pc_q;
    assign hold_issue     = hold_issue_q;
    assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_early_redirect.sv
// Bench for branch_early_redirect: directed scenarios followed by random
// traffic, all checked against a behavioural model of the redirect protocol.

module tb_branch_early_redirect;
    import branch_early_redirect_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   stall, flush, br_valid, pred_taken, ds_valid, redirect_ack;
    logic [31:0]            br_pc, pred_target;
    branch_early_resolved_t resolved;
    logic                   redirect_req, hold_issue;
    logic [31:0]            redirect_pc, mispredict_cnt;

    int unsigned n_checks = 0;
    int unsigned n_bad    = 0;

    // Model: a mismatch is either waiting for its delay slot or being requested.
    bit          m_wait, m_req;
    logic [31:0] m_pc, m_cnt;

    branch_early_redirect #(.DS_OFFSET(32'd8)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .br_valid(br_valid), .br_pc(br_pc), .resolved(resolved),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ds_valid(ds_valid), .redirect_ack(redirect_ack),
        .redirect_req(redirect_req), .redirect_pc(redirect_pc),
        .hold_issue(hold_issue), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clr();
        stall = 0; flush = 0; br_valid = 0; pred_taken = 0; ds_valid = 0;
        redirect_ack = 0; br_pc = 0; pred_target = 0; resolved = '0;
    endtask

    task automatic set_br(input logic [31:0] pc, input bit ce, input bit cs, input bit neg,
                          input bit me, input bit ms, input logic [31:0] tgt,
                          input bit pt, input logic [31:0] ptgt);
        br_valid = 1; br_pc = pc;
        resolved.cond_equal = ce; resolved.cond_sign = cs; resolved.negate = neg;
        resolved.mask_equal = me; resolved.mask_sign = ms; resolved.target = tgt;
        pred_taken = pt; pred_target = ptgt;
    endtask

    task automatic model_reset();
        m_wait = 0; m_req = 0; m_pc = 0; m_cnt = 0;
    endtask

    // Apply one clock of the current inputs to the model and compare after the edge.
    task automatic cycle();
        bit          taken, mis;
        logic [31:0] corr;
        taken = resolved.negate ^ ((resolved.mask_equal & resolved.cond_equal) |
                                   (resolved.mask_sign & resolved.cond_sign));
        corr  = taken ? resolved.target : br_pc + 32'd8;
        mis   = (taken != pred_taken) || (taken && pred_taken && resolved.target != pred_target);
        if (m_req) begin
            if (redirect_ack || flush) m_req = 0;
        end else if (m_wait) begin
            if (flush) m_wait = 0;
            else if (ds_valid && !stall) begin m_wait = 0; m_req = 1; end
        end else if (br_valid && !stall && !flush && mis) begin
            m_pc  = corr;
            m_cnt = m_cnt + 32'd1;
            if (ds_valid) m_req = 1; else m_wait = 1;
        end
        @(posedge clk);
        #1;
        check("req", 32'(redirect_req), 32'(m_req));
        check("hold", 32'(hold_issue), 32'(m_req || m_wait));
        check("cnt", mispredict_cnt, m_cnt);
        if (m_req) check("pc", redirect_pc, m_pc);
    endtask

    initial begin
        clr();
        model_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 32'(redirect_req), 32'd0);
        check("rst_pc", redirect_pc, 32'd0);
        check("rst_hold", 32'(hold_issue), 32'd0);
        check("rst_cnt", mispredict_cnt, 32'd0);
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;

        // BEQ taken, predicted not taken, delay slot dual-issued.
        set_br(32'h8000_0000, 1, 0, 0, 1, 0, 32'h8000_0100, 0, 32'h0);
        ds_valid = 1;
        cycle();
        check("beq_req", 32'(redirect_req), 32'd1);
        check("beq_pc", redirect_pc, 32'h8000_0100);
        clr(); redirect_ack = 1;
        cycle();
        check("beq_drop", 32'(redirect_req), 32'd0);
        check("beq_cnt", mispredict_cnt, 32'd1);
        clr();

        // BNE not taken, predicted taken, delay slot two cycles later.
        set_br(32'h0000_1000, 1, 0, 1, 1, 0, 32'h0000_2000, 1, 32'h0000_2000);
        cycle();
        check("bne_hold", 32'(hold_issue), 32'd1);
        check("bne_noreq", 32'(redirect_req), 32'd0);
        clr();
        cycle();
        ds_valid = 1;
        cycle();
        check("bne_pc", redirect_pc, 32'h0000_1008);
        clr(); redirect_ack = 1;
        cycle();
        clr();

        // BGEZ correctly predicted, then wrong target.
        set_br(32'h0000_3000, 0, 0, 1, 0, 1, 32'h0000_4000, 1, 32'h0000_4000);
        ds_valid = 1;
        cycle();
        check("bgez_ok_req", 32'(redirect_req), 32'd0);
        check("bgez_ok_cnt", mispredict_cnt, 32'd2);
        pred_target = 32'h0000_4444;
        cycle();
        check("bgez_tgt_pc", redirect_pc, 32'h0000_4000);
        clr(); redirect_ack = 1;
        cycle();
        clr();

        // Flush in WAIT_DS, then flush together with ack in REQ.
        set_br(32'h0000_5000, 1, 0, 0, 1, 0, 32'h0000_6000, 0, 32'h0);
        cycle();
        clr(); flush = 1;
        cycle();
        check("flush_wait_req", 32'(hold_issue), 32'd0);
        check("flush_wait_cnt", mispredict_cnt, 32'd4);
        clr();
        set_br(32'h0000_5000, 1, 0, 0, 1, 0, 32'h0000_6000, 0, 32'h0);
        ds_valid = 1;
        cycle();
        clr(); flush = 1; redirect_ack = 1;
        cycle();
        check("flush_ack_req", 32'(redirect_req), 32'd0);
        clr();

        // Stalled mismatch ignored; branch during REQ ignored; reset in REQ.
        set_br(32'h0000_7000, 1, 0, 0, 1, 0, 32'h0000_7700, 0, 32'h0);
        ds_valid = 1; stall = 1;
        cycle();
        check("stall_ign", 32'(hold_issue), 32'd0);
        stall = 0;
        cycle();
        set_br(32'h0000_9000, 1, 0, 0, 1, 0, 32'h0000_9900, 0, 32'h0);
        cycle();
        check("req_ign_pc", redirect_pc, 32'h0000_7700);
        check("req_ign_cnt", mispredict_cnt, 32'd6);
        #2 rst = 1;
        #1;
        check("arst_req", 32'(redirect_req), 32'd0);
        check("arst_hold", 32'(hold_issue), 32'd0);
        check("arst_cnt", mispredict_cnt, 32'd0);
        check("arst_pc", redirect_pc, 32'd0);
        model_reset();
        clr();
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;

        // Counter wraps from all-ones to zero.
        force dut.mispredict_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.mispredict_cnt_q;
        m_cnt = 32'hFFFF_FFFF;
        set_br(32'h0000_a000, 1, 0, 0, 1, 0, 32'h0000_b000, 0, 32'h0);
        ds_valid = 1;
        cycle();
        check("wrap_cnt", mispredict_cnt, 32'd0);
        clr(); redirect_ack = 1;
        cycle();
        clr();

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] tgt;
            tgt = $urandom() & 32'hFFFF_FFFC;
            set_br($urandom() & 32'hFFFF_FFFC, 1'($urandom()), 1'($urandom()), 1'($urandom()),
                   1'($urandom()), 1'($urandom()), tgt, 1'($urandom()),
                   ($urandom_range(0, 1) == 0) ? tgt : ($urandom() & 32'hFFFF_FFFC));
            br_valid     = ($urandom_range(0, 1) == 0);
            stall        = ($urandom_range(0, 4) == 0);
            flush        = ($urandom_range(0, 9) == 0);
            ds_valid     = ($urandom_range(0, 4) < 2);
            redirect_ack = ($urandom_range(0, 4) < 2);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
